// File: rtl/spi_arb_ctrl.sv
// spi_arb_ctrl: round-robin arbiter that shares one SPI master among four requesters,
// with per-frame timeout, illegal-mode rejection and an enforced inter-frame gap.
module spi_arb_ctrl #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd100000,
    parameter logic [7:0]  GAP_CYC     = 8'd4
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [3:0]  req_i,
    input  logic [7:0]  req_mode_i,
    input  logic [63:0] req_wdata_i,
    output logic [3:0]  gnt_o,
    output logic [3:0]  rsp_valid_o,
    output logic        rsp_err_o,
    output logic [15:0] rsp_rdata_o,
    output logic        spi_en_o,
    output logic [1:0]  spi_mode_o,
    output logic [15:0] spi_sdata_o,
    input  logic [15:0] spi_rdata_i,
    input  logic        spi_done_i
);
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        ISSUE = 5'b00010,
        BUSY  = 5'b00100,
        RESP  = 5'b01000,
        GAP   = 5'b10000
    } state_t;

    // A zero gap still costs one GAP cycle so spi_en always sees a low phase there.
    localparam logic [7:0] GAP_LAST = (GAP_CYC == 8'd0) ? 8'd0 : GAP_CYC - 8'd1;

    state_t      state_q;
    logic [1:0]  last_q;
    logic [3:0]  gnt_q;
    logic [3:0]  rsp_valid_q;
    logic        rsp_err_q;
    logic [15:0] rsp_rdata_q;
    logic        spi_en_q;
    logic [1:0]  spi_mode_q;
    logic [15:0] spi_sdata_q;
    logic [19:0] cnt_q;
    logic [7:0]  gap_q;
    logic [1:0]  win_d;
    logic [1:0]  idx;
    logic        hit;

    // Search starts just after the previous winner; k=4 wraps back to last itself.
    always_comb begin
        win_d = last_q;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!hit && req_i[idx]) begin
                win_d = idx;
                hit   = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            spi_en_q    <= 1'b0;
            spi_mode_q  <= 2'd1;
            spi_sdata_q <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: if (|req_i) begin
                    gnt_q       <= 4'b0001 << win_d;
                    last_q      <= win_d;
                    spi_mode_q  <= req_mode_i[{win_d, 1'b0} +: 2];
                    spi_sdata_q <= req_wdata_i[{win_d, 4'b0000} +: 16];
                    state_q     <= ISSUE;
                end
                // Modes 1 and 3 are the only ones the attached master supports.
                ISSUE: if (spi_mode_q[0]) begin
                    spi_en_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= BUSY;
                end else begin
                    rsp_valid_q <= 4'b0001 << last_q;
                    rsp_err_q   <= 1'b1;
                    state_q     <= RESP;
                end
                BUSY: if (spi_done_i) begin
                    rsp_rdata_q <= spi_rdata_i;
                    rsp_valid_q <= 4'b0001 << last_q;
                    spi_en_q    <= 1'b0;
                    state_q     <= RESP;
                end else if (cnt_q == TIMEOUT_CYC - 20'd1) begin
                    rsp_rdata_q <= '0;
                    rsp_valid_q <= 4'b0001 << last_q;
                    rsp_err_q   <= 1'b1;
                    spi_en_q    <= 1'b0;
                    state_q     <= RESP;
                end else begin
                    cnt_q <= cnt_q + 20'd1;
                end
                RESP: begin
                    gap_q   <= '0;
                    state_q <= GAP;
                end
                GAP: if (gap_q >= GAP_LAST) begin
                    state_q <= IDLE;
                end else begin
                    gap_q <= gap_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign spi_en_o    = spi_en_q;
    assign spi_mode_o  = spi_mode_q;
    assign spi_sdata_o = spi_sdata_q;
endmodule

// File: tb/tb_spi_arb_ctrl.sv
// tb_spi_arb_ctrl: scoreboard bench for spi_arb_ctrl with a behavioural SPI master
// whose done delay and read word are set per frame.
module tb_spi_arb_ctrl;
    localparam logic [19:0] TO  = 20'd100;
    localparam logic [7:0]  GAP = 8'd4;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  req_mode;
    logic [63:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        spi_en;
    logic [1:0]  spi_mode;
    logic [15:0] spi_sdata;
    logic [15:0] spi_rdata;
    logic        spi_done;

    spi_arb_ctrl #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .req_i(req), .req_mode_i(req_mode),
        .req_wdata_i(req_wdata), .gnt_o(gnt), .rsp_valid_o(rsp_valid),
        .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata), .spi_en_o(spi_en),
        .spi_mode_o(spi_mode), .spi_sdata_o(spi_sdata), .spi_rdata_i(spi_rdata),
        .spi_done_i(spi_done)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {logic [3:0] g; logic [1:0] m; logic [15:0] d;} gexp_t;
    typedef struct {logic [3:0] v; logic e; logic [15:0] d;} rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;

    int n_vec = 0, n_err = 0;
    int cyc = 0, gnt_cnt = 0, rsp_cnt = 0, gnt_cyc = 0, g2g = 0, rsp_lat = 0;
    int en_rise = 0, en_fall = 0, en_len = 0, low_len = 0, min_low = 1000, en_rises = 0;
    logic en_prev = 1'b0;
    int done_delay = -1;
    logic [15:0] done_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cnt(input string tag, input bit rsp, input int target);
        int n;
        for (n = 0; n < 3000 && (rsp ? rsp_cnt : gnt_cnt) < target; n++) begin
            @(posedge sys_clk);
            #1;
        end
        if (n >= 3000) check(tag, rsp ? rsp_cnt : gnt_cnt, target);
    endtask

    always @(posedge sys_clk) cyc++;

    // Monitor: pops scoreboard entries whenever the DUT pulses gnt or rsp_valid.
    always @(negedge sys_clk) begin
        if (spi_en && !en_prev) begin
            en_rise = cyc;
            low_len = cyc - en_fall;
            if (en_rises > 0 && low_len < min_low) min_low = low_len;
            en_rises++;
        end
        if (!spi_en && en_prev) begin
            en_len  = cyc - en_rise;
            en_fall = cyc;
        end
        en_prev = spi_en;
        if (rst_n && gnt != 4'd0) begin
            if (gq.size() == 0) check("gnt_unexp", gnt, 0);
            else begin
                ge = gq.pop_front();
                check("gnt", gnt, ge.g);
                check("spi_mode", spi_mode, ge.m);
                check("spi_sdata", spi_sdata, ge.d);
            end
            g2g = cyc - gnt_cyc;
            gnt_cyc = cyc;
            gnt_cnt++;
        end
        if (rst_n && rsp_valid != 4'd0) begin
            if (rq.size() == 0) check("rsp_unexp", rsp_valid, 0);
            else begin
                re = rq.pop_front();
                check("rsp_valid", rsp_valid, re.v);
                check("rsp_err", rsp_err, re.e);
                check("rsp_rdata", rsp_rdata, re.d);
            end
            rsp_lat = cyc - gnt_cyc;
            rsp_cnt++;
        end
    end

    // SPI master model: pulses spi_done done_delay cycles after spi_en rises.
    initial begin
        int d;
        spi_done  = 1'b0;
        spi_rdata = '0;
        forever begin
            @(posedge spi_en);
            d = done_delay;
            if (d > 0) begin
                repeat (d - 1) @(posedge sys_clk);
                #1 spi_done = 1'b1;
                spi_rdata = done_data;
                @(posedge sys_clk);
                #1 spi_done = 1'b0;
            end
        end
    end

    initial begin
        int r0;
        rst_n = 1'b0; req = '0; req_mode = '0; req_wdata = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_spi_en", spi_en, 0);
        check("rst_spi_mode", spi_mode, 1);
        check("rst_spi_sdata", spi_sdata, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(posedge sys_clk); #1 rst_n = 1'b1;

        // Round robin with all four requesting continuously.
        done_delay = 10; done_data = 16'hBEEF;
        req_mode = 8'hFF;
        req_wdata = {16'h3333, 16'h2222, 16'h1111, 16'h0C0C};
        gq.push_back('{4'b0001, 2'd3, 16'h0C0C});
        gq.push_back('{4'b0010, 2'd3, 16'h1111});
        gq.push_back('{4'b0100, 2'd3, 16'h2222});
        gq.push_back('{4'b1000, 2'd3, 16'h3333});
        gq.push_back('{4'b0001, 2'd3, 16'h0C0C});
        foreach (gq[i]) rq.push_back('{gq[i].g, 1'b0, 16'hBEEF});
        req = 4'b1111;
        wait_cnt("rr_gnt_wait", 0, 5);
        req = '0;
        wait_cnt("rr_rsp_wait", 1, 5);
        check("rr_g2g", g2g, 3 + GAP + 10);
        check("rr_gap_ok", min_low >= GAP, 1);
        check("rr_en_len", en_len, 10);

        // Single request, data changes after grant must not leak.
        done_delay = 40; done_data = 16'h1234;
        req_mode = 8'h30; req_wdata = 64'hA55A << 32;
        gq.push_back('{4'b0100, 2'd3, 16'hA55A});
        rq.push_back('{4'b0100, 1'b0, 16'h1234});
        req = 4'b0100;
        wait_cnt("single_gnt_wait", 0, 6);
        req = '0; req_wdata = '1; req_mode = '0;
        wait_cnt("single_rsp_wait", 1, 6);
        check("single_en_len", en_len, 40);
        check("single_lat", rsp_lat, 41);
        check("single_sdata_hold", spi_sdata, 16'hA55A);

        // Illegal mode: no frame, error response right after the grant, rdata held.
        r0 = en_rises;
        req_mode = 8'h00; req_wdata = 64'h1111 << 16;
        gq.push_back('{4'b0010, 2'd0, 16'h1111});
        rq.push_back('{4'b0010, 1'b1, 16'h1234});
        req = 4'b0010;
        wait_cnt("ill_gnt_wait", 0, 7);
        req = '0;
        wait_cnt("ill_rsp_wait", 1, 7);
        check("ill_lat", rsp_lat, 1);
        check("ill_no_en", en_rises, r0);

        // Timeout, with a late spi_done that must be ignored.
        done_delay = TO + 1; done_data = 16'hDEAD;
        req_mode = 8'h01; req_wdata = 64'h00000000_0000_7E57;
        gq.push_back('{4'b0001, 2'd1, 16'h7E57});
        rq.push_back('{4'b0001, 1'b1, 16'h0000});
        req = 4'b0001;
        wait_cnt("to_gnt_wait", 0, 8);
        req = '0;
        wait_cnt("to_rsp_wait", 1, 8);
        check("to_en_len", en_len, TO);
        repeat (6) @(posedge sys_clk);
        #1 check("to_rdata_hold", rsp_rdata, 0);

        // spi_done on the very timeout cycle wins.
        done_delay = TO; done_data = 16'h5A5A;
        req_mode = 8'hC0; req_wdata = 64'h6B6B << 48;
        gq.push_back('{4'b1000, 2'd3, 16'h6B6B});
        rq.push_back('{4'b1000, 1'b0, 16'h5A5A});
        req = 4'b1000;
        wait_cnt("edge_gnt_wait", 0, 9);
        req = '0;
        wait_cnt("edge_rsp_wait", 1, 9);
        check("edge_en_len", en_len, TO);
        repeat (3) @(posedge sys_clk);
        #1 check("edge_rdata_hold", rsp_rdata, 16'h5A5A);

        // Reset in BUSY: frame discarded, arbitration restarts from requester 0.
        done_delay = -1;
        req_mode = 8'h03; req_wdata = 64'h0F0F;
        gq.push_back('{4'b0001, 2'd3, 16'h0F0F});
        req = 4'b0001;
        wait_cnt("rst_gnt_wait", 0, 10);
        req = '0;
        repeat (5) @(posedge sys_clk);
        #1 check("busy_en", spi_en, 1);
        #3 rst_n = 1'b0;
        #1 check("rst_async_en", spi_en, 0);
        check("rst_no_rsp", rsp_valid, 0);
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        check("rst_rdata_clr", rsp_rdata, 0);
        done_delay = 20; done_data = 16'h7777;
        req_mode = 8'hC3; req_wdata = {16'h3B3B, 32'h0, 16'h0A0A};
        gq.push_back('{4'b0001, 2'd3, 16'h0A0A});
        rq.push_back('{4'b0001, 1'b0, 16'h7777});
        req = 4'b1001;
        wait_cnt("post_gnt_wait", 0, 11);
        req = '0;
        wait_cnt("post_rsp_wait", 1, 10);
        repeat (10) @(posedge sys_clk);
        #1 check("sb_empty", gq.size() + rq.size(), 0);
        check("rsp_total", rsp_cnt, 10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
